// File: rtl/vga_fb_arbiter_if.sv
// Bundle of APB slave, scanout read port and SRAM port signals for vga_fb_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface vga_fb_arbiter_if;
   logic [31:0] in_paddr;
   logic        in_psel;
   logic        in_penable;
   logic [2:0]  in_pprot;
   logic        in_pwrite;
   logic [31:0] in_pwdata;
   logic [3:0]  in_pstrb;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;

   logic        scan_req;
   logic [18:0] scan_addr;
   logic        scan_gnt;
   logic        scan_rvalid;
   logic [31:0] scan_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [18:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport slave (
      input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
      output in_pready, in_prdata, in_pslverr,
      input  scan_req, scan_addr,
      output scan_gnt, scan_rvalid, scan_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata
   );

   modport master (
      output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
      input  in_pready, in_prdata, in_pslverr,
      output scan_req, scan_addr,
      input  scan_gnt, scan_rvalid, scan_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer SRAM arbiter: scanout reads have priority, APB accesses
// are forced through after MAX_STARVE consecutive denied cycles.
module vga_fb_arbiter #(
   parameter logic [31:0] FB_BASE    = 32'h2100_0000,
   parameter int unsigned FB_WORDS   = 307200,
   parameter int unsigned MAX_STARVE = 4
) (
   input logic             clock,
   input logic             reset,
   vga_fb_arbiter_if.slave bus
);
   localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
   // Exclusive end address, widened so a window touching 4 GiB cannot wrap.
   localparam logic [32:0] FB_END = {1'b0, FB_BASE} + (33'(FB_WORDS) << 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        r_state;
   logic [31:0]   r_paddr;
   logic [31:0]   r_pwdata;
   logic          r_pwrite;
   logic [3:0]    r_pstrb;
   logic [SW-1:0] r_starve_cnt;
   logic          r_pready;
   logic          r_pslverr;
   logic [31:0]   r_prdata;
   logic          r_scan_rvalid;

   logic [31:0]   w_offset;
   logic [18:0]   w_index;
   logic          w_in_range;
   logic          w_starved;
   logic          w_apb_req;
   logic          w_apb_gnt;
   logic          w_scan_gnt;
   logic          w_unused;

   assign w_offset   = r_paddr - FB_BASE;
   assign w_index    = w_offset[20:2];
   assign w_in_range = (r_paddr >= FB_BASE) && ({1'b0, r_paddr} < FB_END) &&
                       (r_paddr[1:0] == 2'b00);
   assign w_starved  = (r_starve_cnt == SW'(MAX_STARVE));

   // Reset gates both requesters so the SRAM sees nothing during the reset cycle.
   assign w_apb_req  = !reset && (r_state == REQ) && w_in_range;
   assign w_apb_gnt  = w_apb_req && (!bus.scan_req || w_starved);
   assign w_scan_gnt = !reset && bus.scan_req && !w_apb_gnt;

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      if (w_scan_gnt) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = bus.scan_addr;
      end else if (w_apb_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = r_pwrite;
         bus.mem_addr  = w_index;
         bus.mem_wdata = r_pwrite ? r_pwdata : 32'd0;
         bus.mem_wstrb = r_pwrite ? r_pstrb : 4'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_pwrite      <= 1'b0;
         r_pstrb       <= '0;
         r_starve_cnt  <= '0;
         r_pready      <= 1'b0;
         r_pslverr     <= 1'b0;
         r_prdata      <= '0;
         r_scan_rvalid <= 1'b0;
      end else begin
         r_scan_rvalid <= w_scan_gnt;
         r_pready      <= 1'b0;

         if (w_apb_gnt) begin
            r_starve_cnt <= '0;
         end else if (w_apb_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (bus.in_psel && !bus.in_penable) begin
                  r_paddr  <= bus.in_paddr;
                  r_pwrite <= bus.in_pwrite;
                  r_pwdata <= bus.in_pwdata;
                  r_pstrb  <= bus.in_pstrb;
                  r_state  <= REQ;
               end
            end
            REQ: begin
               if (!w_in_range) begin
                  r_state   <= DONE;
                  r_pready  <= 1'b1;
                  r_pslverr <= 1'b1;
               end else if (w_apb_gnt) begin
                  r_state <= DATA;
               end
            end
            DATA: begin
               // SRAM read data arrives the cycle after the granted access.
               if (!r_pwrite) begin
                  r_prdata <= bus.mem_rdata;
               end
               r_state   <= DONE;
               r_pready  <= 1'b1;
               r_pslverr <= 1'b0;
            end
            DONE: begin
               r_state   <= IDLE;
               r_pslverr <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_pready   = r_pready;
   assign bus.in_pslverr  = r_pslverr;
   assign bus.in_prdata   = r_prdata;
   assign bus.scan_gnt    = w_scan_gnt;
   assign bus.scan_rvalid = r_scan_rvalid;
   assign bus.scan_rdata  = bus.mem_rdata;

   assign w_unused = ^{bus.in_pprot, w_offset[31:21], w_offset[1:0]};
endmodule
